rc4_key_dispatcher: RTL and testbench

Central scheduler for the parallel RC4 brute-force cores. It hands out candidate secret keys from a shared 22-bit key space to idle cores using round-robin arbitration, and records which key each core is working on. It collects pass/fail results, broadcasts stop_all when a core reports a correct key, and reports the winning key or exhaustion of the key space. It sits in the top level between the switch/key inputs and the generated core array, and replaces per-core stride counting.

---
 rtl/rc4_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rc4_key_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_rc4_key_dispatcher.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 brute-force key dispatcher.
package rc4_pkg;

    localparam int KEY_WIDTH = 22;
    localparam logic [KEY_WIDTH-1:0] KEY_MAX = 22'h3FFFFF;

    typedef logic [KEY_WIDTH-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, wrapping around. The caller owns the pointer register.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    generate
        if (N == 1) begin : g_single
            // A single requester is always the winner.
            assign grant = req;
        end else begin : g_multi
            logic [2*N-1:0] req_dbl;
            logic [N-1:0]   rot_req;
            logic [N-1:0]   rot_grant;
            logic [2*N-1:0] grant_dbl;

            // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
            always_comb begin
                req_dbl   = {req, req} >> ptr;
                rot_req   = req_dbl[N-1:0];
                rot_grant = rot_req & (~rot_req + N'(1));
                grant_dbl = {{N{1'b0}}, rot_grant} << ptr;
                grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];
            end
        end
    endgenerate

endmodule

// File: rtl/rc4_key_dispatcher.sv
// Hands out sequential candidate keys to idle RC4 cores, tracks which key
// each core holds, and reports the winning key or exhaustion of the space.
module rc4_key_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int KEY_WIDTH = rc4_pkg::KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = KEY_WIDTH'(rc4_pkg::KEY_MAX)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_req,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_ok,
    output logic [NUM_CORES-1:0] key_load,
    output logic [KEY_WIDTH-1:0] key_value,
    output logic                 stop_all,
    output logic                 found,
    output logic [KEY_WIDTH-1:0] found_key,
    output logic                 exhausted,
    output logic                 busy,
    output logic [KEY_WIDTH-1:0] last_issued
);
    import rc4_pkg::*;

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    disp_state_t          state_reg, state_next;
    logic [KEY_WIDTH-1:0] next_key_reg;
    logic [KEY_WIDTH-1:0] last_issued_reg;
    logic [KEY_WIDTH-1:0] found_key_reg;
    logic [KEY_WIDTH-1:0] key_table_reg [NUM_CORES];
    logic [NUM_CORES-1:0] outstanding_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic                 found_reg;
    logic                 exhausted_reg;
    logic                 stop_all_reg;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant_raw;
    logic [NUM_CORES-1:0] done_valid;
    logic [NUM_CORES-1:0] ok_hits;
    logic                 hit_any;
    logic                 issue;
    logic                 restart;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     ptr_after;

    // A core finishing this cycle is not re-armed until its result is absorbed.
    assign eligible   = core_req & ~outstanding_reg & ~core_done;
    assign done_valid = core_done & outstanding_reg;
    assign ok_hits    = done_valid & core_ok;
    assign hit_any    = |ok_hits;
    assign restart    = start && (state_reg inside {ST_IDLE, ST_FOUND, ST_EXHAUSTED});

    rr_arbiter #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr_reg),
        .grant (grant_raw)
    );

    // Encode the granted core and the lowest-index successful core.
    always_comb begin
        grant_idx = '0;
        win_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (grant_raw[i]) grant_idx = PTR_W'(i);
            if (ok_hits[i])   win_idx   = PTR_W'(i);
        end
        ptr_after = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    // Next-state logic and the combinational key handout.
    always_comb begin
        state_next = state_reg;
        key_load   = '0;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (hit_any) begin
                    state_next = ST_FOUND;
                end else if (|grant_raw) begin
                    key_load = grant_raw;
                    issue    = 1'b1;
                    if (next_key_reg == KEY_MAX) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hit_any)                  state_next = ST_FOUND;
                else if (outstanding_reg == '0) state_next = ST_EXHAUSTED;
            end
            ST_FOUND, ST_EXHAUSTED: begin
                if (start) state_next = ST_DISPATCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign key_value   = issue ? next_key_reg : '0;
    assign busy        = (state_reg == ST_DISPATCH) || (state_reg == ST_DRAIN);
    assign stop_all    = stop_all_reg;
    assign found       = found_reg;
    assign found_key   = found_key_reg;
    assign exhausted   = exhausted_reg;
    assign last_issued = last_issued_reg;

    // Control state, key counter, outstanding flags and result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            next_key_reg    <= '0;
            last_issued_reg <= '0;
            found_key_reg   <= '0;
            outstanding_reg <= '0;
            ptr_reg         <= '0;
            found_reg       <= 1'b0;
            exhausted_reg   <= 1'b0;
            stop_all_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (restart) begin
                next_key_reg    <= '0;
                found_key_reg   <= '0;
                outstanding_reg <= '0;
                ptr_reg         <= '0;
                found_reg       <= 1'b0;
                exhausted_reg   <= 1'b0;
                stop_all_reg    <= 1'b0;
            end else begin
                if (state_reg == ST_DISPATCH || state_reg == ST_DRAIN)
                    outstanding_reg <= (outstanding_reg & ~done_valid) | (issue ? grant_raw : '0);
                if (issue) begin
                    last_issued_reg <= next_key_reg;
                    ptr_reg         <= ptr_after;
                    if (next_key_reg != KEY_MAX) next_key_reg <= next_key_reg + KEY_WIDTH'(1);
                end
                if (state_next == ST_FOUND && state_reg != ST_FOUND) begin
                    found_reg     <= 1'b1;
                    found_key_reg <= key_table_reg[win_idx];
                    stop_all_reg  <= 1'b1;
                end
                if (state_next == ST_EXHAUSTED && state_reg != ST_EXHAUSTED) begin
                    exhausted_reg <= 1'b1;
                    stop_all_reg  <= 1'b1;
                end
            end
        end
    end

    // Key held by each core; only read while that core is outstanding.
    always_ff @(posedge clk) begin
        if (issue) key_table_reg[grant_idx] <= next_key_reg;
    end

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Directed bench for rc4_key_dispatcher: a full-space instance and a
// KEY_MAX=5 instance share stimulus, each checked every cycle against a
// behavioural model, plus hand-computed spot checks.
module tb_rc4_key_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] core_req = '0;
    logic [1:0] core_done = '0;
    logic [1:0] core_ok = '0;

    logic [1:0]  key_load    [2];
    logic [21:0] key_value   [2];
    logic        stop_all    [2];
    logic        found       [2];
    logic [21:0] found_key   [2];
    logic        exhausted   [2];
    logic        busy        [2];
    logic [21:0] last_issued [2];

    int total = 0;
    int bad   = 0;

    rc4_key_dispatcher #(.NUM_CORES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .core_req(core_req), .core_done(core_done), .core_ok(core_ok),
        .key_load(key_load[0]), .key_value(key_value[0]), .stop_all(stop_all[0]),
        .found(found[0]), .found_key(found_key[0]), .exhausted(exhausted[0]),
        .busy(busy[0]), .last_issued(last_issued[0])
    );

    rc4_key_dispatcher #(.NUM_CORES(2), .KEY_MAX(22'd5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .core_req(core_req), .core_done(core_done), .core_ok(core_ok),
        .key_load(key_load[1]), .key_value(key_value[1]), .stop_all(stop_all[1]),
        .found(found[1]), .found_key(found_key[1]), .exhausted(exhausted[1]),
        .busy(busy[1]), .last_issued(last_issued[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, d, got, want, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 handing out, 2 waiting for last results,
    // 3 found, 4 exhausted.
    int          m_mode [2];
    logic [21:0] m_next [2];
    logic [21:0] m_last [2];
    logic [21:0] m_fkey [2];
    logic [21:0] m_tab  [2][2];
    bit          m_out  [2][2];
    int          m_ptr  [2];
    bit          m_found[2];
    bit          m_exh  [2];
    logic [21:0] m_kmax [2] = '{22'h3FFFFF, 22'd5};

    int          g_core;
    int          w_core;
    bit          none_out;
    logic [1:0]  e_load;
    logic [21:0] e_val;

    // Compare every output every cycle, then advance the model by one clock.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_mode[d] = 0; m_next[d] = '0; m_last[d] = '0; m_fkey[d] = '0;
                m_out[d][0] = 0; m_out[d][1] = 0; m_ptr[d] = 0;
                m_found[d] = 0; m_exh[d] = 0;
            end
            w_core = -1;
            g_core = -1;
            for (int i = 0; i < 2; i++)
                if (w_core < 0 && core_done[i] && core_ok[i] && m_out[d][i]) w_core = i;
            if (m_mode[d] == 1 && w_core < 0)
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % 2;
                    if (g_core < 0 && core_req[c] && !m_out[d][c] && !core_done[c]) g_core = c;
                end
            e_load = (g_core >= 0) ? 2'(1 << g_core) : 2'b00;
            e_val  = (g_core >= 0) ? m_next[d] : 22'd0;

            chk("key_load",    d, 32'(key_load[d]),    32'(e_load));
            chk("key_value",   d, 32'(key_value[d]),   32'(e_val));
            chk("busy",        d, 32'(busy[d]),        32'(m_mode[d] == 1 || m_mode[d] == 2));
            chk("stop_all",    d, 32'(stop_all[d]),    32'(m_mode[d] == 3 || m_mode[d] == 4));
            chk("found",       d, 32'(found[d]),       32'(m_found[d]));
            chk("found_key",   d, 32'(found_key[d]),   32'(m_fkey[d]));
            chk("exhausted",   d, 32'(exhausted[d]),   32'(m_exh[d]));
            chk("last_issued", d, 32'(last_issued[d]), 32'(m_last[d]));

            if (reset_n) begin
                if (m_mode[d] == 0 || m_mode[d] == 3 || m_mode[d] == 4) begin
                    if (start) begin
                        m_mode[d] = 1; m_next[d] = '0; m_fkey[d] = '0;
                        m_found[d] = 0; m_exh[d] = 0; m_ptr[d] = 0;
                        m_out[d][0] = 0; m_out[d][1] = 0;
                    end
                end else begin
                    none_out = !m_out[d][0] && !m_out[d][1];
                    for (int i = 0; i < 2; i++)
                        if (core_done[i]) m_out[d][i] = 0;
                    if (w_core >= 0) begin
                        m_mode[d] = 3; m_found[d] = 1; m_fkey[d] = m_tab[d][w_core];
                    end else if (g_core >= 0) begin
                        m_tab[d][g_core] = m_next[d];
                        m_out[d][g_core] = 1;
                        m_last[d] = m_next[d];
                        m_ptr[d] = (g_core + 1) % 2;
                        if (m_next[d] == m_kmax[d]) m_mode[d] = 2;
                        else m_next[d] = m_next[d] + 22'd1;
                    end else if (m_mode[d] == 2 && none_out) begin
                        m_mode[d] = 4; m_exh[d] = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt[6];
    int over;

    initial begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_key_load", 0, 32'(key_load[0]), 32'h0);
        chk("rst_busy",     0, 32'(busy[0]),     32'h0);
        chk("rst_stop_all", 0, 32'(stop_all[0]), 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Two requesters, fresh search: keys 0 then 1 round-robin.
        start = 1'b1; tick(); start = 1'b0;
        core_req = 2'b11;
        @(negedge clk);
        chk("first_load",  0, 32'(key_load[0]),  32'h1);
        chk("first_value", 0, 32'(key_value[0]), 32'h0);
        tick();
        @(negedge clk);
        chk("second_load",  0, 32'(key_load[0]),  32'h2);
        chk("second_value", 0, 32'(key_value[0]), 32'h1);
        tick();
        @(negedge clk);
        chk("idle_load",   0, 32'(key_load[0]),    32'h0);
        chk("last_is_one", 0, 32'(last_issued[0]), 32'h1);
        tick();

        // Core 1 finishes with a request held: no grant until next cycle.
        core_done = 2'b10;
        @(negedge clk);
        chk("done_cycle_load", 0, 32'(key_load[0]), 32'h0);
        tick();
        core_done = 2'b00;
        @(negedge clk);
        chk("regrant_load",  0, 32'(key_load[0]),  32'h2);
        chk("regrant_value", 0, 32'(key_value[0]), 32'h2);
        tick();

        // Cycle core 0 until it holds key 0x2A.
        for (int k = 0; k < 40; k++) begin
            core_done = 2'b01; tick();
            core_done = 2'b00; tick();
        end
        @(negedge clk);
        chk("last_2a", 0, 32'(last_issued[0]), 32'h2A);
        tick();
        core_done = 2'b01; core_ok = 2'b01;
        @(negedge clk);
        chk("found_cycle_load", 0, 32'(key_load[0]), 32'h0);
        tick();
        core_done = 2'b00; core_ok = 2'b00;
        @(negedge clk);
        chk("found_flag", 0, 32'(found[0]),     32'h1);
        chk("found_key",  0, 32'(found_key[0]), 32'h2A);
        chk("found_stop", 0, 32'(stop_all[0]),  32'h1);
        chk("found_busy", 0, 32'(busy[0]),      32'h0);
        tick();
        core_done = 2'b10; core_ok = 2'b10; tick();
        core_done = 2'b00; core_ok = 2'b00;
        @(negedge clk);
        chk("late_done_key", 0, 32'(found_key[0]), 32'h2A);
        tick();

        // Exhaustion on the KEY_MAX=5 instance.
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        over = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            core_done = (c % 3 == 2) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (key_load[1] != 2'b00) begin
                if (key_value[1] > 22'd5) over++;
                else cnt[key_value[1]]++;
            end
            tick();
        end
        core_done = 2'b00;
        for (int k = 0; k < 6; k++) chk($sformatf("issued_once_%0d", k), 1, 32'(cnt[k]), 32'd1);
        chk("beyond_max", 1, 32'(over), 32'd0);
        @(negedge clk);
        chk("exhausted", 1, 32'(exhausted[1]), 32'h1);
        chk("exh_stop",  1, 32'(stop_all[1]),  32'h1);
        chk("exh_found", 1, 32'(found[1]),     32'h0);
        tick();

        // Simultaneous success on keys 7 (core 0) and 8 (core 1).
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        start = 1'b1; core_req = 2'b01; tick(); start = 1'b0;
        tick();
        core_done = 2'b01; tick();
        core_done = 2'b00; tick();
        core_req = 2'b11; tick();
        for (int r = 0; r < 3; r++) begin
            core_done = 2'b11; tick();
            core_done = 2'b00; tick(); tick();
        end
        core_done = 2'b11; core_ok = 2'b11; tick();
        core_done = 2'b00; core_ok = 2'b00;
        @(negedge clk);
        chk("dual_found",     0, 32'(found[0]),     32'h1);
        chk("dual_found_key", 0, 32'(found_key[0]), 32'h7);
        tick();

        // Async reset in the middle of a search at key 100.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        for (int k = 0; k < 99; k++) begin
            core_done = 2'b01; tick();
            core_done = 2'b00; tick();
        end
        @(negedge clk);
        chk("last_100", 0, 32'(last_issued[0]), 32'd100);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_key_load",  0, 32'(key_load[0]),    32'h0);
        chk("arst_key_value", 0, 32'(key_value[0]),   32'h0);
        chk("arst_busy",      0, 32'(busy[0]),        32'h0);
        chk("arst_stop",      0, 32'(stop_all[0]),    32'h0);
        chk("arst_found",     0, 32'(found[0]),       32'h0);
        chk("arst_found_key", 0, 32'(found_key[0]),   32'h0);
        chk("arst_exhausted", 0, 32'(exhausted[0]),   32'h0);
        chk("arst_last",      0, 32'(last_issued[0]), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        chk("post_rst_load",  0, 32'(key_load[0]),  32'h1);
        chk("post_rst_value", 0, 32'(key_value[0]), 32'h0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
